cache_mem_responder: RTL

//  Backing-store responder for the cache controller's memory-side port (mem_read/mem_write/mem_address/
//  mem_write_data -> mem_read_data). Word-addressed storage with configurable read latency, request

---
 rtl/cache_mem_pkg.sv | 25 ++
 rtl/mem_req_detect.sv | 45 ++++
 rtl/cache_mem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cache_mem_pkg.sv
// cache_mem_pkg: shared types and helpers for the cache memory-side responder.
//   resp_state_e      read-response FSM states
//   ERR_DATA_DEFAULT  data returned for out-of-range reads
//   word_idx()        byte address -> word index (untruncated)
//   addr_in_range()   full 32-bit range check, no wrap
package cache_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } resp_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    function automatic logic [29:0] word_idx(input logic [31:0] addr);
        return 30'(addr >> 2);
    endfunction

    // Widened compare so DEPTH_WORDS*4 never overflows 32 bits.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth_words);
        return {32'd0, addr} < (64'(depth_words) * 64'd4);
    endfunction

endpackage

// File: rtl/mem_req_detect.sv
// mem_req_detect: turns held request levels into single-cycle request pulses.
//   clk, reset_n        clock, asynchronous active-low reset
//   mem_read/mem_write  request levels from the cache
//   mem_address         byte address
//   mem_write_data      write data
//   rd_req/wr_req       new read/write request this cycle
module mem_req_detect #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mem_read,
    input  logic          mem_write,
    input  logic [AW-1:0] mem_address,
    input  logic [DW-1:0] mem_write_data,
    output logic          rd_req,
    output logic          wr_req
);

    logic          prev_read;
    logic          prev_write;
    logic [AW-1:0] prev_address;
    logic [DW-1:0] prev_write_data;

    // Previous samples reset to 0 so a level already high at release is a new request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_read       <= 1'b0;
            prev_write      <= 1'b0;
            prev_address    <= '0;
            prev_write_data <= '0;
        end else begin
            prev_read       <= mem_read;
            prev_write      <= mem_write;
            prev_address    <= mem_address;
            prev_write_data <= mem_write_data;
        end
    end

    assign rd_req = mem_read && (!prev_read || mem_address != prev_address);
    assign wr_req = mem_write && (!prev_write || mem_address != prev_address ||
                                  mem_write_data != prev_write_data);

endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: word-addressed backing store for the cache memory-side port.
//   clk, reset_n     clock, asynchronous active-low reset (storage is not cleared)
//   mem_read         read request level
//   mem_write        write request level
//   mem_address      byte address, bits [1:0] ignored
//   mem_write_data   write data
//   mem_read_data    read data (combinational when READ_LATENCY=0, else valid with mem_rvalid)
//   mem_rvalid       one-cycle response pulse (always 0 when READ_LATENCY=0)
//   mem_busy         read in flight
//   err_overflow     sticky: read request dropped
//   err_range        sticky: out-of-range access
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    DEPTH_WORDS  = 1024,
    parameter int                    READ_LATENCY = 0,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA     = ERR_DATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_address,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_rvalid,
    output logic                  mem_busy,
    output logic                  err_overflow,
    output logic                  err_range
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int LD = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;
    localparam resp_state_e FIRST = (READ_LATENCY == 1) ? RESP : WAIT;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic                  rd_req;
    logic                  wr_req;
    logic [IW-1:0]         cur_idx;
    logic                  cur_ok;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] cur_word;
    logic [DATA_WIDTH-1:0] act_word;
    logic [DATA_WIDTH-1:0] hold_data;
    resp_state_e           state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         act_idx;
    logic                  act_ok;
    logic [IW-1:0]         pend_idx;
    logic                  pend_ok;
    logic                  pend_valid;
    logic                  lat_req;
    logic                  start_cur;
    logic                  to_pend;
    logic                  drop;

    mem_req_detect #(.AW(32), .DW(DATA_WIDTH)) u_detect (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .rd_req         (rd_req),
        .wr_req         (wr_req)
    );

    assign cur_idx = IW'(word_idx(mem_address));
    assign cur_ok  = addr_in_range(mem_address, DEPTH_WORDS);
    assign wr_en   = wr_req && cur_ok;

    always_ff @(posedge clk) begin
        if (wr_en) mem[cur_idx] <= mem_write_data;
    end

    // A write committing this cycle is forwarded so reads see the new data.
    assign cur_word = !cur_ok ? ERR_DATA : wr_en ? mem_write_data : mem[cur_idx];
    assign act_word = !act_ok ? ERR_DATA :
                      (wr_en && cur_idx == act_idx) ? mem_write_data : mem[act_idx];

    assign lat_req   = rd_req && READ_LATENCY != 0;
    assign mem_busy  = state != IDLE;
    // In RESP with an empty pending slot the new read starts straight away (no bubble).
    assign start_cur = lat_req && (state == IDLE || (state == RESP && !pend_valid));
    assign to_pend   = lat_req && state == WAIT && !pend_valid;
    assign drop      = lat_req && mem_busy && pend_valid;

    assign mem_rvalid    = READ_LATENCY != 0 && state == RESP;
    assign mem_read_data = !reset_n ? '0 :
                           READ_LATENCY == 0 ? (mem_read ? cur_word : hold_data) :
                           state == RESP ? act_word : hold_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            act_idx      <= '0;
            act_ok       <= 1'b0;
            pend_idx     <= '0;
            pend_ok      <= 1'b0;
            pend_valid   <= 1'b0;
            hold_data    <= '0;
            err_overflow <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            hold_data <= mem_read_data;
            if (drop) err_overflow <= 1'b1;
            if ((rd_req || wr_req) && !cur_ok) err_range <= 1'b1;
            if (to_pend) begin
                pend_valid <= 1'b1;
                pend_idx   <= cur_idx;
                pend_ok    <= cur_ok;
            end
            case (state)
                IDLE: begin
                    if (start_cur) begin
                        state   <= FIRST;
                        cnt     <= CW'(LD);
                        act_idx <= cur_idx;
                        act_ok  <= cur_ok;
                    end
                end
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (cnt <= CW'(1)) state <= RESP;
                end
                RESP: begin
                    if (pend_valid) begin
                        state      <= FIRST;
                        cnt        <= CW'(LD);
                        act_idx    <= pend_idx;
                        act_ok     <= pend_ok;
                        pend_valid <= 1'b0;
                    end else if (start_cur) begin
                        state   <= FIRST;
                        cnt     <= CW'(LD);
                        act_idx <= cur_idx;
                        act_ok  <= cur_ok;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
